// File: rtl/song_reader_pkg.sv
// Shared widths, state encoding and end-of-song marker for the song reader
// and its song ROM.
package song_reader_pkg;

  localparam int SONG_W = 4;
  localparam int IDX_W  = 5;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int ADDR_W = SONG_W + IDX_W;
  localparam int ROM_W  = NOTE_W + DUR_W;

  localparam logic [ROM_W-1:0] END_MARK = '0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    PLAY   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/song_reader_dff.sv
// Async active-high reset flip-flop cell; every register resets to zero.
module song_reader_dff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_q <= '0;
    else       o_q <= i_d;
  end

endmodule

// File: rtl/song_rom.sv
// Song ROM with a registered read port; data follows the address by one cycle.
// Each word is {note, duration}; an all-zero word marks end of song.
module song_rom
  import song_reader_pkg::*;
(
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [ROM_W-1:0]  o_data
);

  function automatic logic [ROM_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [SONG_W-1:0] s;
    logic [IDX_W-1:0]  i;
    s = a[ADDR_W-1:IDX_W];
    i = a[IDX_W-1:0];
    rom_word = END_MARK;
    case (s)
      4'd2: begin
        case (i)
          5'd0:    rom_word = {6'h10, 6'd8};
          5'd1:    rom_word = {6'h12, 6'd4};
          default: rom_word = END_MARK;
        endcase
      end
      4'd3: begin
        case (i)
          5'd0:    rom_word = {6'h20, 6'd3};
          5'd1:    rom_word = {6'h21, 6'd5};
          5'd2:    rom_word = {6'h22, 6'd7};
          5'd3:    rom_word = {6'h23, 6'd9};
          default: rom_word = END_MARK;
        endcase
      end
      // Song 7 fills every slot, so it ends on the last index rather than a marker.
      4'd7:    rom_word = {1'b1, i, ({1'b0, i} + 6'd1)};
      default: rom_word = END_MARK;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    o_data <= rom_word(i_addr);
  end

endmodule

// File: rtl/song_reader.sv
// Walks one song of the ROM and hands each {note, duration} to the note player
// with a new_note / note_done handshake; pulses song_done at the end.
module song_reader
  import song_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              reset_player,
  input  logic [SONG_W-1:0] song,
  input  logic              note_done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROM_W-1:0]  rom_data,
  output logic [NOTE_W-1:0] note,
  output logic [DUR_W-1:0]  duration,
  output logic              new_note,
  output logic              song_done
);

  logic [2:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [SONG_W-1:0] r_song;
  logic [NOTE_W-1:0] r_note;
  logic [DUR_W-1:0]  r_dur;
  logic              r_new_note;
  logic              r_song_done;

  state_t            w_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [SONG_W-1:0] w_song_nxt;
  logic [NOTE_W-1:0] w_note_nxt;
  logic [DUR_W-1:0]  w_dur_nxt;
  logic              w_new_note_nxt;
  logic              w_song_done_nxt;

  assign w_state = state_t'(r_state);

  always_comb begin
    w_state_nxt     = w_state;
    w_idx_nxt       = r_idx;
    w_song_nxt      = r_song;
    w_note_nxt      = r_note;
    w_dur_nxt       = r_dur;
    w_new_note_nxt  = 1'b0;
    w_song_done_nxt = 1'b0;
    // Restart beats every other transition, including a concurrent note_done.
    if (reset_player) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
      w_note_nxt  = '0;
      w_dur_nxt   = '0;
    end else begin
      case (w_state)
        IDLE: begin
          if (play) begin
            w_song_nxt  = song;
            w_state_nxt = FETCH;
          end
        end
        FETCH: begin
          if (play) w_state_nxt = DECODE;
        end
        DECODE: begin
          if (rom_data == END_MARK) begin
            w_state_nxt     = DONE;
            w_song_done_nxt = 1'b1;
          end else begin
            w_note_nxt     = rom_data[ROM_W-1:DUR_W];
            w_dur_nxt      = rom_data[DUR_W-1:0];
            w_new_note_nxt = 1'b1;
            w_state_nxt    = PLAY;
          end
        end
        PLAY: begin
          if (note_done) begin
            if (r_idx == '1) begin
              w_state_nxt     = DONE;
              w_song_done_nxt = 1'b1;
            end else begin
              w_idx_nxt   = r_idx + 1'b1;
              w_state_nxt = FETCH;
            end
          end
        end
        DONE:    w_state_nxt = DONE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  song_reader_dff #(.W(3))      u_state (.i_clk(clk), .i_rst(reset), .i_d(w_state_nxt),     .o_q(r_state));
  song_reader_dff #(.W(IDX_W))  u_idx   (.i_clk(clk), .i_rst(reset), .i_d(w_idx_nxt),       .o_q(r_idx));
  song_reader_dff #(.W(SONG_W)) u_song  (.i_clk(clk), .i_rst(reset), .i_d(w_song_nxt),      .o_q(r_song));
  song_reader_dff #(.W(NOTE_W)) u_note  (.i_clk(clk), .i_rst(reset), .i_d(w_note_nxt),      .o_q(r_note));
  song_reader_dff #(.W(DUR_W))  u_dur   (.i_clk(clk), .i_rst(reset), .i_d(w_dur_nxt),       .o_q(r_dur));
  song_reader_dff #(.W(1))      u_newn  (.i_clk(clk), .i_rst(reset), .i_d(w_new_note_nxt),  .o_q(r_new_note));
  song_reader_dff #(.W(1))      u_done  (.i_clk(clk), .i_rst(reset), .i_d(w_song_done_nxt), .o_q(r_song_done));

  assign rom_addr  = {r_song, r_idx};
  assign note      = r_note;
  assign duration  = r_dur;
  assign new_note  = r_new_note;
  assign song_done = r_song_done;

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader driving the song_rom contents of songs 2, 3 and 7.
module tb_song_reader;
  import song_reader_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              play = 1'b0;
  logic              reset_player = 1'b0;
  logic              note_done = 1'b0;
  logic [SONG_W-1:0] song = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [ROM_W-1:0]  rom_data;
  logic [NOTE_W-1:0] note;
  logic [DUR_W-1:0]  duration;
  logic              new_note;
  logic              song_done;

  int checks = 0;
  int errors = 0;
  int pulses;
  int addr_moves;
  logic [NOTE_W-1:0] exp_note;
  logic [DUR_W-1:0]  exp_dur;

  always #5 clk = ~clk;

  song_reader dut (
    .clk(clk), .reset(reset), .play(play), .reset_player(reset_player),
    .song(song), .note_done(note_done), .rom_addr(rom_addr), .rom_data(rom_data),
    .note(note), .duration(duration), .new_note(new_note), .song_done(song_done)
  );

  song_rom u_rom (.i_clk(clk), .i_addr(rom_addr), .o_data(rom_data));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_done();
    note_done = 1'b1;
    step(1);
    note_done = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_note", note, 0);
    chk("rst_dur", duration, 0);
    chk("rst_new", new_note, 0);
    chk("rst_done", song_done, 0);
    chk("rst_addr", rom_addr, 0);
    reset = 1'b0;

    // Basic start on song 2
    song = 4'd2;
    play = 1'b1;
    step(1);
    chk("t1_fetch_addr", rom_addr, 9'h040);
    chk("t1_fetch_new", new_note, 0);
    step(1);
    chk("t1_decode_new", new_note, 0);
    step(1);
    chk("t1_n0_new", new_note, 1);
    chk("t1_n0_note", note, 6'h10);
    chk("t1_n0_dur", duration, 6'd8);
    step(5);
    chk("t1_n0_pulse_once", new_note, 0);
    chk("t1_n0_hold", note, 6'h10);
    pulse_done();
    chk("t1_fetch1_addr", rom_addr, 9'h041);
    step(2);
    chk("t1_n1_new", new_note, 1);
    chk("t1_n1_note", note, 6'h12);
    chk("t1_n1_dur", duration, 6'd4);
    step(3);
    pulse_done();
    chk("t1_fetch2_addr", rom_addr, 9'h042);
    step(1);
    chk("t1_decode2_done", song_done, 0);
    step(1);
    chk("t1_done_pulse", song_done, 1);
    chk("t1_done_new", new_note, 0);
    chk("t1_done_note_hold", note, 6'h12);
    step(1);
    chk("t1_done_single", song_done, 0);

    // Spurious note_done in DONE
    pulse_done();
    chk("t6_done_nd_done", song_done, 0);
    chk("t6_done_nd_addr", rom_addr, 9'h042);
    step(2);
    chk("t6_done_stay", song_done, 0);

    // Restart into IDLE with play low, then spurious note_done in IDLE
    play = 1'b0;
    reset_player = 1'b1;
    step(1);
    reset_player = 1'b0;
    chk("t6_rp_note", note, 0);
    chk("t6_rp_dur", duration, 0);
    chk("t6_rp_addr", rom_addr, 9'h040);
    pulse_done();
    step(2);
    chk("t6_idle_addr", rom_addr, 9'h040);
    chk("t6_idle_new", new_note, 0);

    // Pause in FETCH for 10 cycles, with a spurious note_done in its first cycle
    play = 1'b1;
    step(1);
    chk("t3_fetch_new", new_note, 0);
    play = 1'b0;
    pulses = 0;
    addr_moves = 0;
    note_done = 1'b1;
    step(1);
    note_done = 1'b0;
    pulses += int'(new_note);
    addr_moves += int'(rom_addr != 9'h040);
    for (int c = 0; c < 9; c++) begin
      step(1);
      pulses += int'(new_note);
      addr_moves += int'(rom_addr != 9'h040);
    end
    chk("t3_pause_pulses", pulses, 0);
    chk("t3_pause_addr_moves", addr_moves, 0);
    play = 1'b1;
    step(1);
    chk("t3_resume_decode", new_note, 0);
    step(1);
    chk("t3_resume_new", new_note, 1);
    chk("t3_resume_note", note, 6'h10);

    // Restart from PLAY; new song 3 picked up at IDLE exit
    reset_player = 1'b1;
    song = 4'd3;
    step(1);
    reset_player = 1'b0;
    chk("t4a_note", note, 0);
    chk("t4a_addr", rom_addr, 9'h040);
    step(1);
    chk("t4a_fetch_addr", rom_addr, 9'h060);
    step(2);
    chk("t4a_n0_note", note, 6'h20);
    chk("t4a_n0_dur", duration, 6'd3);
    pulse_done();
    step(2);
    chk("t4a_n1_note", note, 6'h21);
    pulse_done();
    step(2);
    chk("t4a_n2_new", new_note, 1);
    chk("t4a_n2_note", note, 6'h22);
    chk("t4a_n2_dur", duration, 6'd7);
    step(1);
    reset_player = 1'b1;
    song = 4'd2;
    step(1);
    reset_player = 1'b0;
    chk("t4b_note", note, 0);
    chk("t4b_dur", duration, 0);
    chk("t4b_idx0", rom_addr, 9'h060);
    step(1);
    chk("t4b_fetch_addr", rom_addr, 9'h040);
    step(1);
    chk("t4b_decode_new", new_note, 0);
    step(1);
    chk("t4b_new", new_note, 1);
    chk("t4b_note_new", note, 6'h10);

    // reset_player together with note_done: restart wins, no increment
    reset_player = 1'b1;
    note_done = 1'b1;
    play = 1'b0;
    step(1);
    reset_player = 1'b0;
    note_done = 1'b0;
    chk("t4c_addr", rom_addr, 9'h040);
    chk("t4c_note", note, 0);
    step(2);
    chk("t4c_addr_hold", rom_addr, 9'h040);

    // Full 32-entry song without end marker
    song = 4'd7;
    play = 1'b1;
    step(1);
    chk("t2_fetch_addr", rom_addr, 9'h0E0);
    pulses = 0;
    for (int k = 0; k < 32; k++) begin
      step(2);
      exp_note = 6'(32 + k);
      exp_dur  = 6'(k + 1);
      pulses += int'(new_note);
      chk($sformatf("t2_note%0d", k), note, exp_note);
      chk($sformatf("t2_dur%0d", k), duration, exp_dur);
      chk($sformatf("t2_addr%0d", k), rom_addr, 9'h0E0 + 9'(k));
      pulse_done();
    end
    chk("t2_pulses", pulses, 32);
    chk("t2_done_pulse", song_done, 1);
    chk("t2_no_wrap", rom_addr, 9'h0FF);
    step(1);
    chk("t2_done_single", song_done, 0);
    chk("t2_no_wrap_hold", rom_addr, 9'h0FF);

    // Async reset asserted mid-DECODE, between clock edges
    reset_player = 1'b1;
    song = 4'd2;
    step(1);
    reset_player = 1'b0;
    step(3);
    chk("t5_pre_note", note, 6'h10);
    pulse_done();
    step(1);
    chk("t5_decode_addr", rom_addr, 9'h041);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_note", note, 0);
    chk("t5_async_dur", duration, 0);
    chk("t5_async_addr", rom_addr, 0);
    chk("t5_async_new", new_note, 0);
    chk("t5_async_done", song_done, 0);
    play = 1'b0;
    step(1);
    reset = 1'b0;
    step(3);
    chk("t5_idle_new", new_note, 0);
    chk("t5_idle_addr", rom_addr, 0);
    play = 1'b1;
    step(1);
    chk("t5_fetch_addr", rom_addr, 9'h040);
    step(1);
    chk("t5_decode_new", new_note, 0);
    step(1);
    chk("t5_new", new_note, 1);
    chk("t5_note", note, 6'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/song_reader.md
Name: song_reader

Overview:
- Responder on the MCU↔player interface. Consumes play / reset_player / song and returns song_done.
- Walks a song ROM entry by entry and hands each note and duration to the note player with a new_note / note_done handshake.
- Sits between the MCU and the note player. The ROM is an external module with 1-cycle read latency.
- End of song is an all-zero ROM entry or completion of the last index. On end, the block pulses song_done.

Parameters:
- SONG_W, 4: song-select width (16 songs).
- IDX_W, 5: note-index width (32 entries per song).
- NOTE_W, 6: note-code width.
- DUR_W, 6: duration width.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- play, input, 1: from MCU. High = run; low = pause.
- reset_player, input, 1: from MCU. Synchronous restart to the start of the song.
- song, input, SONG_W: song number from the MCU.
- note_done, input, 1: single-cycle pulse from the note player; current note has finished.
- rom_addr, output, SONG_W+IDX_W: equals {song_q, idx}. Combinational from registers.
- rom_data, input, NOTE_W+DUR_W: {note, duration}, note in the MSBs. Valid 1 cycle after rom_addr.
- note, output, NOTE_W: current note, registered.
- duration, output, DUR_W: current duration, registered.
- new_note, output, 1: single-cycle pulse; note and duration are valid this cycle.
- song_done, output, 1: single-cycle pulse at end of song.

Behaviour:
- Async reset:
  - state = IDLE; idx = 0; song_q = 0.
  - note, duration, new_note and song_done = 0.
- Priority: reset > reset_player > all other transitions.
- reset_player (sampled at clk):
  - Next state is IDLE; idx = 0; note, duration, new_note and song_done = 0.
  - Takes effect in any state, including the same cycle as note_done or the song_done pulse.
- States:
  - IDLE:
    - If play = 1: song_q <= song, go to FETCH.
    - Otherwise stay.
  - FETCH:
    - rom_addr is presented.
    - If play = 1: go to DECODE.
    - Otherwise hold (paused).
  - DECODE:
    - rom_data is valid.
    - If rom_data == 0: go to DONE.
    - Otherwise latch note and duration, set new_note <= 1, go to PLAY.
    - DECODE always completes; it does not check play.
  - PLAY:
    - new_note is high only in the first PLAY cycle.
    - On note_done (accepted in any PLAY cycle, including the first, and regardless of play):
      - If idx == all-ones: go to DONE.
      - Otherwise idx <= idx + 1, go to FETCH.
    - note and duration hold their values until the next DECODE.
  - DONE:
    - song_done = 1 in the first DONE cycle only (registered pulse).
    - Remains in DONE until reset_player or reset.
    - idx is not incremented past all-ones; there is no wrap.
- Latency:
  - play rising while in IDLE at cycle N: FETCH at N+1, DECODE at N+2, new_note and valid note at N+3.
  - note_done at cycle M: next new_note at M+3.
- Pause:
  - play low in FETCH freezes the block; no new_note is issued while play is low.
  - A note already in PLAY still completes on note_done.
- Mid-song changes of song are ignored until the next IDLE exit. The MCU issues reset_player on a song change.
- A note_done outside PLAY is ignored.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, FETCH, DECODE, PLAY, DONE);
  - width constants SONG_W, IDX_W, NOTE_W, DUR_W;
  - the end-marker constant (all-zero).
- The song ROM is a separate sub-module: song_rom (synchronous read, 1-cycle latency). It is not contained in song_reader.
- State register and datapath registers are built from the codebase's async-reset flip-flop cells.

Test Plan:
1. Basic start:
   - Stimulus: ROM song 2 = {(0x10, 8), (0x12, 4), 0}. song = 2; play goes high at cycle 5.
   - Response: rom_addr = 0x040 at cycle 6; new_note at cycle 8 with note = 0x10, duration = 8.
   - After note_done at cycle 20: new_note at cycle 23 with note = 0x12, duration = 4.
   - After the next note_done: the zero entry is read and song_done pulses for exactly 1 cycle.
2. Full song, no end marker:
   - Stimulus: all 32 entries nonzero; note_done answered each time.
   - Response: 32 new_note pulses; song_done 1 cycle after the 32nd note_done; rom_addr never wraps to idx 0.
3. Pause:
   - Stimulus: drop play while in FETCH for 10 cycles.
   - Response: no new_note and rom_addr stable during the pause; new_note 2 cycles after play returns.
4. Restart:
   - Stimulus: reset_player during PLAY of note 3.
   - Response: note = 0, idx = 0 next cycle; with play high, new_note for entry 0 of the new song 3 cycles later.
   - Stimulus: reset_player in the same cycle as note_done.
   - Response: restart wins; no increment.
5. Async reset:
   - Stimulus: assert reset mid-DECODE, between clock edges.
   - Response: all outputs 0 immediately, with no clock edge.
   - After release: state IDLE; no new_note until play is sampled high.
6. Spurious note_done:
   - Stimulus: note_done pulses in IDLE, FETCH and DONE.
   - Response: no change in idx, no state change, no extra song_done pulse.
